// File: rtl/circuit2_pkg.sv
// Shared definitions for the resource-shared circuit2 datapath:
// FSM state encoding, shared-ALU opcodes and the default operand width.
package circuit2_pkg;

    localparam int DEF_DATAWIDTH = 32;

    // Sequencer states, one per cycle of a transaction.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADD_D = 3'd1,
        ADD_E = 3'd2,
        SUB_F = 3'd3,
        CMP   = 3'd4,
        SEL   = 3'd5,
        SHIFT = 3'd6
    } state_t;

    // Shared-ALU operation select.
    typedef logic [1:0] alu_op_t;

    localparam alu_op_t ALU_ADD = 2'd0;
    localparam alu_op_t ALU_SUB = 2'd1;
    localparam alu_op_t ALU_CMP = 2'd2;

endpackage

// File: rtl/shared_alu.sv
// Single combinational add/sub/compare unit shared across the sequencer's
// arithmetic cycles. Results wrap modulo 2^DATAWIDTH; flags are signed.
module shared_alu
    import circuit2_pkg::*;
#(
    parameter int DATAWIDTH = DEF_DATAWIDTH
) (
    input  alu_op_t                     op,
    input  logic signed [DATAWIDTH-1:0] p,
    input  logic signed [DATAWIDTH-1:0] q,
    output logic signed [DATAWIDTH-1:0] result,
    output logic                        lt,
    output logic                        eq
);

    // Add for ALU_ADD, subtract otherwise; compare flags are always valid.
    always_comb begin
        result = p + q;
        case (op)
            ALU_SUB, ALU_CMP: result = p - q;
            default:          result = p + q;
        endcase
        lt = (p < q);
        eq = (p == q);
    end

endmodule

// File: rtl/circuit2_seq.sv
// Multi-cycle circuit2 datapath: one shared ALU sequenced by an FSM computes
// d=a+b, e=a+c, f=a-b, the signed d/e compare, the g/h selects and the final
// shifts, delivering x/z six cycles after a start is accepted in IDLE.
module circuit2_seq
    import circuit2_pkg::*;
#(
    parameter int DATAWIDTH = DEF_DATAWIDTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic signed [DATAWIDTH-1:0] a,
    input  logic signed [DATAWIDTH-1:0] b,
    input  logic signed [DATAWIDTH-1:0] c,
    output logic                        busy,
    output logic                        done,
    output logic signed [DATAWIDTH-1:0] x,
    output logic signed [DATAWIDTH-1:0] z,
    output logic                        dlte,
    output logic                        deqe
);

    state_t state_q;
    state_t state_d;

    logic signed [DATAWIDTH-1:0] a_r;
    logic signed [DATAWIDTH-1:0] b_r;
    logic signed [DATAWIDTH-1:0] c_r;
    logic signed [DATAWIDTH-1:0] d_r;
    logic signed [DATAWIDTH-1:0] e_r;
    logic signed [DATAWIDTH-1:0] f_r;
    logic signed [DATAWIDTH-1:0] g_r;
    logic signed [DATAWIDTH-1:0] h_r;

    alu_op_t                     alu_op;
    logic signed [DATAWIDTH-1:0] alu_p;
    logic signed [DATAWIDTH-1:0] alu_q;
    logic signed [DATAWIDTH-1:0] alu_res;
    logic                        alu_lt;
    logic                        alu_eq;

    logic signed [DATAWIDTH-1:0] g_c;
    logic signed [DATAWIDTH-1:0] h_c;

    shared_alu #(
        .DATAWIDTH (DATAWIDTH)
    ) u_alu (
        .op     (alu_op),
        .p      (alu_p),
        .q      (alu_q),
        .result (alu_res),
        .lt     (alu_lt),
        .eq     (alu_eq)
    );

    // Select network used in SEL; h reuses g so equal d/e yields g in both.
    assign g_c = dlte ? d_r : e_r;
    assign h_c = deqe ? g_c : f_r;

    // Next-state sequencing and ALU operand steering for the current state.
    always_comb begin
        state_d = state_q;
        alu_op  = ALU_ADD;
        alu_p   = a_r;
        alu_q   = b_r;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ADD_D;
                end
            end
            ADD_D: begin
                alu_op  = ALU_ADD;
                alu_p   = a_r;
                alu_q   = b_r;
                state_d = ADD_E;
            end
            ADD_E: begin
                alu_op  = ALU_ADD;
                alu_p   = a_r;
                alu_q   = c_r;
                state_d = SUB_F;
            end
            SUB_F: begin
                alu_op  = ALU_SUB;
                alu_p   = a_r;
                alu_q   = b_r;
                state_d = CMP;
            end
            CMP: begin
                alu_op  = ALU_CMP;
                alu_p   = d_r;
                alu_q   = e_r;
                state_d = SEL;
            end
            SEL: begin
                state_d = SHIFT;
            end
            SHIFT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register plus registered handshake flags; busy stays low in the
    // first working cycle and done pulses in the cycle after SHIFT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d != IDLE) && (state_d != ADD_D);
            done    <= (state_q == SHIFT);
        end
    end

    // Operand capture on accept and per-state intermediate registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r <= '0;
            b_r <= '0;
            c_r <= '0;
            d_r <= '0;
            e_r <= '0;
            f_r <= '0;
            g_r <= '0;
            h_r <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_r <= a;
                        b_r <= b;
                        c_r <= c;
                    end
                end
                ADD_D:   d_r <= alu_res;
                ADD_E:   e_r <= alu_res;
                SUB_F:   f_r <= alu_res;
                SEL: begin
                    g_r <= g_c;
                    h_r <= h_c;
                end
                default: ;
            endcase
        end
    end

    // Observable results: flags from CMP, zero-fill shifts in SHIFT; all
    // hold their value between transactions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dlte <= 1'b0;
            deqe <= 1'b0;
            x    <= '0;
            z    <= '0;
        end else begin
            if (state_q == CMP) begin
                dlte <= alu_lt;
                deqe <= alu_eq;
            end
            if (state_q == SHIFT) begin
                x <= g_r << dlte;
                z <= h_r >> deqe;
            end
        end
    end

endmodule

// File: tb/tb_circuit2_seq.sv
// Scoreboard bench for circuit2_seq: the stimulus process pushes the
// expected result and its due cycle on every accepted start; a monitor pops
// and compares on each done pulse.
module tb_circuit2_seq;

    localparam int W = 32;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] c = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] x;
    logic [W-1:0] z;
    logic         dlte;
    logic         deqe;

    typedef struct {
        int           due;
        logic [W-1:0] x;
        logic [W-1:0] z;
        logic         lt;
        logic         eq;
    } exp_t;

    exp_t sb[$];
    int   cyc        = 0;
    int   acc        = -100;
    int   vectors    = 0;
    int   miscompares = 0;

    circuit2_seq #(.DATAWIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .c     (c),
        .busy  (busy),
        .done  (done),
        .x     (x),
        .z     (z),
        .dlte  (dlte),
        .deqe  (deqe)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference computed from the arithmetic rules: wrap, signed compare,
    // select, then doubling / halving as the zero-fill shifts.
    function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                   input logic [W-1:0] ic, input int due);
        exp_t r;
        logic signed [W-1:0] d, e, f, g, h;
        logic [W-1:0] gu, hu;
        d = ia + ib;
        e = ia + ic;
        f = ia - ib;
        r.lt = (d < e);
        r.eq = (d == e);
        g = r.lt ? d : e;
        h = r.eq ? g : f;
        gu = g;
        hu = h;
        r.x = r.lt ? gu * 2 : gu;
        r.z = r.eq ? hu / 2 : hu;
        r.due = due;
        return r;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // One cycle of stimulus: check busy against the accept history, then
    // drive inputs and record the expected result if the block is free.
    task automatic step(input bit s, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic [W-1:0] ic);
        @(negedge clk);
        chk("busy", {31'b0, busy}, {31'b0, (cyc >= acc + 1) && (cyc <= acc + 5)});
        start = s;
        a = ia;
        b = ib;
        c = ic;
        if (s && rst_n && (cyc + 1 >= acc + 7)) begin
            acc = cyc + 1;
            sb.push_back(model(ia, ib, ic, acc + 6));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, pick(), pick(), pick());
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, {31'b0, busy}, '0);
        chk({tag, "_done"}, {31'b0, done}, '0);
        chk({tag, "_x"}, x, '0);
        chk({tag, "_z"}, z, '0);
        chk({tag, "_dlte"}, {31'b0, dlte}, '0);
        chk({tag, "_deqe"}, {31'b0, deqe}, '0);
    endtask

    // Monitor: every done pulse must match the oldest outstanding result
    // on its due cycle; a due result with no done is reported as missing.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL spurious_done: got done=1 expected no pending result (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("done_cycle", cyc, e.due);
                    chk("x", x, e.x);
                    chk("z", z, e.z);
                    chk("dlte", {31'b0, dlte}, {31'b0, e.lt});
                    chk("deqe", {31'b0, deqe}, {31'b0, e.eq});
                end
            end else if (sb.size() > 0 && cyc >= sb[0].due) begin
                vectors++;
                miscompares++;
                $display("FAIL missing_done: got done=0 expected done at cycle %0d (cycle %0d)", sb[0].due, cyc);
                void'(sb.pop_front());
            end
        end
    end

    logic [W-1:0] ta [4] = '{32'd5, 32'd4, 32'd1, 32'h7FFF_FFFF};
    logic [W-1:0] tbv[4] = '{32'd3, 32'd6, 32'd9, 32'd1};
    logic [W-1:0] tc [4] = '{32'd10, 32'd6, 32'd2, 32'd0};

    initial begin
        #1;
        chk_zero("reset");
        idle(2);
        rst_n = 1'b1;
        idle(1);

        // Directed vectors, one transaction each.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, ta[i], tbv[i], tc[i]);
            idle(8);
        end

        // Start asserted through busy and SHIFT with other operands: ignored.
        step(1'b1, 32'd5, 32'd3, 32'd10);
        idle(1);
        repeat (5) step(1'b1, 32'd99, 32'd1, 32'd2);
        idle(8);

        // Start held high: one result every seven cycles.
        repeat (21) step(1'b1, pick(), pick(), pick());
        idle(8);

        // Reset while in SUB_F discards the request immediately.
        step(1'b1, 32'd5, 32'd3, 32'd10);
        idle(3);
        rst_n = 1'b0;
        #1;
        chk_zero("midreset");
        sb.delete();
        acc = -100;
        idle(2);
        rst_n = 1'b1;
        step(1'b1, 32'd4, 32'd6, 32'd6);
        idle(8);

        // Random traffic with boundary-heavy operands.
        repeat (400) step($urandom_range(0, 2) == 0, pick(), pick(), pick());
        idle(10);

        chk("drain", sb.size(), '0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
